// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: HI/LO unit op encodings, unit FSM states,
// default datapath width and the opcode/funct constants used by decode.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    // HI/LO unit operation select
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } md_state_t;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // SPECIAL funct codes
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned magnitude result of the iterative datapath into the
// architectural HI/LO values. Multiply negates the whole double-width
// product; divide negates quotient and remainder independently.
module muldiv_sign_fix
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_div,
    input  logic               neg_lo,
    input  logic               neg_hi,
    input  logic [2*WIDTH-1:0] mag,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    // Apply the result sign(s) captured at accept time
    always_comb begin
        if (is_div) begin
            lo = neg_lo ? -mag[WIDTH-1:0]       : mag[WIDTH-1:0];
            hi = neg_hi ? -mag[2*WIDTH-1:WIDTH] : mag[2*WIDTH-1:WIDTH];
        end else begin
            {hi, lo} = neg_lo ? -mag : mag;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit. One bit per cycle on operand
// magnitudes, sign fix-up folded into the transition to FIN.
// Build option: define MULDIV_DIV_EN to build the restoring divider; without
// it DIV/DIVU complete one edge after accept with err=1 and HI/LO untouched.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    md_state_t          state, state_nxt;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic               is_div_r, neg_lo, neg_hi, skip;
    logic               idle_or_fin, accept, op_div, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;
    logic [WIDTH:0]     mul_sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]     rem_sh, rem_sub;
`endif

    assign idle_or_fin = (state == ST_IDLE) || (state == ST_FIN);
    assign accept      = start && idle_or_fin;
    assign op_div      = md_is_div(op);
    assign a_neg       = md_is_signed(op) && a[WIDTH-1];
    assign b_neg       = md_is_signed(op) && b[WIDTH-1];
    assign a_mag       = a_neg ? -a : a;
    assign b_mag       = b_neg ? -b : b;
    assign b_zero      = (b == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: skip covers divide-by-zero and the divider-less build,
    // both of which spend one cycle in DIV so completion lands on edge 1
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FIN: state_nxt = accept ? (op_div ? ST_DIV : ST_MUL) : ST_IDLE;
            ST_MUL:          if (cnt == LAST) state_nxt = ST_FIN;
            ST_DIV:          if (skip || cnt == LAST) state_nxt = ST_FIN;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == ST_MUL) || (state == ST_DIV);
        done = (state == ST_FIN);
    end

    // One iteration: shift-add multiply (multiplier in acc low half) or
    // restoring divide (remainder in acc high half, quotient shifts in low)
    always_comb begin
        acc_step = acc;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef MULDIV_DIV_EN
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, opnd};
`endif
        if (state == ST_MUL) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
`ifdef MULDIV_DIV_EN
        else if (state == ST_DIV) begin
            acc_step = (rem_sh >= {1'b0, opnd}) ? {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                                : {rem_sh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
        end
`endif
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_div (is_div_r),
        .neg_lo (neg_lo),
        .neg_hi (neg_hi),
        .mag    (acc),
        .hi     (fix_hi),
        .lo     (fix_lo)
    );

    // Operand capture, iteration, MTHI/MTLO and result write-back.
    // A start in IDLE/FIN takes priority over a same-cycle HI/LO write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            opnd     <= '0;
            cnt      <= '0;
            is_div_r <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            skip     <= 1'b0;
            err      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept) begin
            // divide-by-zero preloads its architectural result {a, all ones}
            acc      <= (op_div && b_zero) ? {a, {WIDTH{1'b1}}}
                                           : {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
            opnd     <= op_div ? b_mag : a_mag;
            cnt      <= '0;
            is_div_r <= op_div;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
`ifdef MULDIV_DIV_EN
            skip     <= op_div && b_zero;
`else
            skip     <= op_div;
`endif
            err      <= 1'b0;
        end else if (idle_or_fin) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end else if (state_nxt == ST_FIN) begin
            if (skip) begin
                err <= 1'b1;
`ifdef MULDIV_DIV_EN
                hi  <= acc[2*WIDTH-1:WIDTH];
                lo  <= acc[WIDTH-1:0];
`endif
            end else begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end else begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32). Expected results come from
// a behavioural 64-bit arithmetic model pushed to a scoreboard queue at
// issue time and popped when done rises. Follows MULDIV_DIV_EN if defined.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, err;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    // {latency[7:0], err, hi[31:0], lo[31:0]}
    logic [72:0] exp_q[$];

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [72:0] model(input logic [1:0] o, input logic [31:0] x, y, ch, cl);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        model = {8'd1, 1'b1, ch, cl};
        case (o)
            OP_MULT:  begin p = sx * sy; model = {8'd33, 1'b0, p[63:0]}; end
            OP_MULTU: begin p = ux * uy; model = {8'd33, 1'b0, p[63:0]}; end
`ifdef MULDIV_DIV_EN
            OP_DIV: begin
                if (y == 0) model = {8'd1, 1'b1, x, 32'hFFFF_FFFF};
                else begin q = sx / sy; r = sx % sy; model = {8'd33, 1'b0, r[31:0], q[31:0]}; end
            end
            OP_DIVU: begin
                if (y == 0) model = {8'd1, 1'b1, x, 32'hFFFF_FFFF};
                else begin q = ux / uy; r = ux % uy; model = {8'd33, 1'b0, r[31:0], q[31:0]}; end
            end
`endif
            default: ;
        endcase
    endfunction

    // push expectation, drive start through the accept edge, return #1 after it
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, y);
        logic [72:0] e;
        e = model(o, x, y, m_hi, m_lo);
        exp_q.push_back(e);
        m_hi = e[63:32];
        m_lo = e[31:0];
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // count edges after accept until done (bounded)
    task automatic wait_done(output logic [72:0] obs);
        int lat;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        obs = {8'(lat), err, hi, lo};
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        #3;
        checks++;
        if ({busy, done, err, hi, lo} !== '0) begin
            errors++;
            $display("FAIL reset_async got busy=%b done=%b err=%b hi=%h lo=%h want all zero", busy, done, err, hi, lo);
        end
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        checks++;
        if ({busy, done, err, hi, lo} !== '0) begin
            errors++;
            $display("FAIL reset_hold got busy=%b done=%b err=%b hi=%h lo=%h want all zero", busy, done, err, hi, lo);
        end
    endtask

    task automatic test_mul();
        logic [65:0] v [7];
        logic [72:0] obs, e;
        v = '{ {OP_MULTU, 32'hFFFF_FFFF, 32'd2},
               {OP_MULT,  32'hFFFF_FFFD, 32'd5},
               {OP_MULT,  32'h8000_0000, 32'h8000_0000},
               {OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF},
               {OP_MULTU, 32'h8000_0000, 32'h8000_0000},
               {OP_MULT,  32'd0,         32'h0001_2345},
               {OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF} };
        for (int i = 0; i < 11; i++) begin
            if (i < 7) start_op(v[i][65:64], v[i][63:32], v[i][31:0]);
            else       start_op(2'($urandom_range(0, 1)), $urandom, $urandom);
            wait_done(obs);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mul[%0d] got lat=%0d err=%b hi=%h lo=%h want lat=%0d err=%b hi=%h lo=%h",
                         i, obs[72:65], obs[64], obs[63:32], obs[31:0], e[72:65], e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_div();
        logic [65:0] v [7];
        logic [72:0] obs, e;
        v = '{ {OP_DIV,  32'hFFFF_FFF9, 32'd2},
               {OP_DIVU, 32'd7,         32'd0},
               {OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF},
               {OP_DIV,  32'd7,         32'hFFFF_FFFE},
               {OP_DIVU, 32'hFFFF_FFFF, 32'd3},
               {OP_DIV,  32'hFFFF_FFF9, 32'd0},
               {OP_DIVU, 32'd5,         32'd9} };
        for (int i = 0; i < 11; i++) begin
            if (i < 7) start_op(v[i][65:64], v[i][63:32], v[i][31:0]);
            else       start_op(2'($urandom_range(2, 3)), $urandom, $urandom_range(1, 32'h00FF_FFFF));
            wait_done(obs);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL div[%0d] got lat=%0d err=%b hi=%h lo=%h want lat=%0d err=%b hi=%h lo=%h",
                         i, obs[72:65], obs[64], obs[63:32], obs[31:0], e[72:65], e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_err_clear();
        logic [72:0] obs, e;
        start_op(OP_DIVU, 32'd7, 32'd0);
        wait_done(obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL divzero got lat=%0d err=%b hi=%h lo=%h want lat=%0d err=%b hi=%h lo=%h",
                     obs[72:65], obs[64], obs[63:32], obs[31:0], e[72:65], e[64], e[63:32], e[31:0]);
        end
        start_op(OP_MULTU, 32'd6, 32'd7);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL err_clear_on_accept got err=%b busy=%b want err=0 busy=1", err, busy);
        end
        wait_done(obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL after_err got lat=%0d err=%b hi=%h lo=%h want lat=%0d err=%b hi=%h lo=%h",
                     obs[72:65], obs[64], obs[63:32], obs[31:0], e[72:65], e[64], e[63:32], e[31:0]);
        end
    endtask

    task automatic test_mtx();
        logic [72:0] obs, e;
        logic [31:0] old_lo;
        @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_1234;
        @(posedge clk); #1; hi_we = 1'b0; m_hi = 32'hA5A5_1234;
        checks++;
        if (hi !== m_hi) begin errors++; $display("FAIL mthi got hi=%h want %h", hi, m_hi); end
        @(negedge clk); lo_we = 1'b1; wdata = 32'h0BAD_C0DE;
        @(posedge clk); #1; lo_we = 1'b0; m_lo = 32'h0BAD_C0DE;
        checks++;
        if (lo !== m_lo || hi !== m_hi) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
        // start and MTLO in the same cycle: the write must be dropped
        old_lo = m_lo;
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start_op(OP_MULTU, 32'd3, 32'd4);
        lo_we = 1'b0;
        checks++;
        if (lo !== old_lo) begin errors++; $display("FAIL start_beats_mtlo got lo=%h want %h", lo, old_lo); end
        wait_done(obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL mtx_mul got lat=%0d err=%b hi=%h lo=%h want lat=%0d err=%b hi=%h lo=%h",
                     obs[72:65], obs[64], obs[63:32], obs[31:0], e[72:65], e[64], e[63:32], e[31:0]);
        end
    endtask

    task automatic test_busy_ignore();
        logic [72:0] obs, e;
        logic [31:0] old_hi, hi_mid;
        int lat;
        old_hi = m_hi;
        hi_mid = '0;
        start_op(OP_MULTU, 32'h0001_2345, 32'h0000_6789);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 9)  begin start = 1'b1; op = OP_DIVU; a = 32'd99; b = 32'd0; end
            if (lat == 10) start = 1'b0;
            if (lat == 11) begin hi_we = 1'b1; wdata = 32'hCAFE_F00D; end
            if (lat == 12) begin hi_we = 1'b0; hi_mid = hi; end
            @(posedge clk); #1;
            lat++;
        end
        obs = {8'(lat), err, hi, lo};
        checks++;
        if (hi_mid !== old_hi) begin errors++; $display("FAIL hi_during_mul got %h want %h", hi_mid, old_hi); end
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL busy_ignore got lat=%0d err=%b hi=%h lo=%h want lat=%0d err=%b hi=%h lo=%h",
                     obs[72:65], obs[64], obs[63:32], obs[31:0], e[72:65], e[64], e[63:32], e[31:0]);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL fin_to_idle got done=%b busy=%b want done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [72:0] obs, e;
        logic        saw_done;
        @(negedge clk);
`ifdef MULDIV_DIV_EN
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
`else
        start = 1'b1; op = OP_MULTU; a = 32'd1000; b = 32'd7;
`endif
        @(posedge clk); #1; start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, hi, lo} !== '0) begin
            errors++;
            $display("FAIL abort_reset got busy=%b done=%b err=%b hi=%h lo=%h want all zero", busy, done, err, hi, lo);
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got done pulse want none"); end
        @(posedge clk); #2;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        start_op(OP_MULT, 32'hFFFF_FF9C, 32'd7);
        wait_done(obs);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL post_reset_mult got lat=%0d err=%b hi=%h lo=%h want lat=%0d err=%b hi=%h lo=%h",
                     obs[72:65], obs[64], obs[63:32], obs[31:0], e[72:65], e[64], e[63:32], e[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_err_clear();
        test_mtx();
        test_busy_ignore();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width; legal values are even and 8..64.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only while busy=0.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a, b  input  WIDTH  multiplicand/dividend (a) and multiplier/divisor (b); captured on accept.
REQ-007 hi_we, lo_we  input  1  MTHI/MTLO write enables.
REQ-008 wdata  input  WIDTH  data for MTHI/MTLO.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  divide-by-zero or unsupported op on the last completed operation.
REQ-012 hi, lo  output  WIDTH  architectural HI/LO registers, always readable (MFHI/MFLO).

Function
REQ-013 FSM states: IDLE, MUL, DIV, FIN.
- busy=1 in MUL and DIV only.
- done=1 in FIN only.
REQ-014 Accept: start=1 in IDLE or FIN latches op/a/b.
- MULT/MULTU go to MUL; DIV/DIVU go to DIV.
- Divide with b=0 goes directly to FIN.
REQ-015 MUL: iterative shift-add on operand magnitudes, one bit per cycle, exactly WIDTH cycles, then FIN.
REQ-016 DIV: restoring division on magnitudes, one quotient bit per cycle, exactly WIDTH cycles, then FIN.
REQ-017 Latency: accept at edge 0, FIN (done=1) at edge WIDTH+1; hi/lo and err update on that same edge.
REQ-018 Multiply result: {hi,lo} = full 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
REQ-019 Divide result: lo = quotient, hi = remainder.
- Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-020 Sign fix-up is applied on the FIN transition and adds no cycle.
REQ-021 Signed overflow (most-negative / -1): lo = most-negative value, hi = 0, err = 0.
REQ-022 Divide by zero: FIN at edge 1, hi = a, lo = all ones, err = 1.
REQ-023 err is cleared on every new accept and held until the next FIN.
REQ-024 start while busy=1 is ignored with no queueing; op/a/b are not re-sampled.
REQ-025 hi_we/lo_we while busy=1 are ignored.
REQ-026 In IDLE/FIN, hi_we/lo_we write wdata on the next edge.
REQ-027 In IDLE/FIN, start and a write in the same cycle: start wins and the write is dropped.
REQ-028 hi/lo hold their value between operations; they are not disturbed during MUL/DIV.
REQ-029 FIN with no new start returns to IDLE on the next edge.

Reset
REQ-030 reset=1 forces IDLE, hi=0, lo=0, busy=0, done=0, err=0, independent of clk.
REQ-031 reset during MUL/DIV aborts the operation: no done pulse, and hi/lo read 0 after reset.
REQ-032 First accept is possible on the first rising edge after reset deasserts.

Configuration
REQ-033 Macro MULDIV_DIV_EN defined: DIV/DIVU are implemented as specified.
REQ-034 MULDIV_DIV_EN undefined: no divider logic is built.
- DIV/DIVU go straight to FIN at edge 1 with hi/lo unchanged and err=1.
- Multiply behaviour is unchanged.

Structure
REQ-035 Shared package mips_pkg holds:
- MD_OP encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
- the FSM state enumeration;
- the default WIDTH constant;
- existing opcode/funct constants, extended with MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MFLO 010010, MTHI 010001, MTLO 010011.
REQ-036 One sub-module, muldiv_sign_fix (combinational magnitude-to-signed correction), is instantiated once.

Verification
REQ-037 Reset, then MULTU a=0xFFFFFFFF b=2 -> done at edge 33, hi=0x00000001, lo=0xFFFFFFFE, err=0.
REQ-038 MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIVU a=7 b=0 -> done at edge 1, hi=7, lo=0xFFFFFFFF, err=1; without MULDIV_DIV_EN, hi/lo unchanged, err=1.
REQ-040 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, err=0.
REQ-041 start with a new op at edge 10 of a MULTU, plus hi_we at edge 12 -> both ignored; original result returned at edge 33.
REQ-042 reset pulse at edge 15 of a DIVU -> no done pulse, hi=lo=0, busy=0; a new MULT accepted immediately after completes correctly.
